// File: rtl/apb_completer_regfile_if.sv
// APB completer-side bus bundle: master drives request fields, slave returns pready/pslverr/prdata.
// Pure wiring, no latency; flow control is the psel/penable/pready handshake itself.
interface apb_completer_regfile_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  addr;
    logic [2:0]  prot;
    logic [3:0]  pstrobe;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    modport master (
        output psel, penable, pwrite, addr, prot, pstrobe, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, addr, prot, pstrobe, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB completer with a 32x32 register file, byte strobes, ID word 0 and a privileged window.
// Setup edge to pready is WAIT_CYCLES+1 edges; the master is held off by pready=0 during WAIT.
module apb_completer_regfile #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned NUM_WORDS   = 32,
    parameter int unsigned PRIV_BASE   = 24,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input logic                    clk,
    input logic                    reset,
    apb_completer_regfile_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic [4:0]  lat_addr;
    logic        lat_write;
    logic        lat_err;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_strb;

    logic [31:0] mem [NUM_WORDS];

    logic        setup;
    logic        setup_err;
    logic [4:0]  acc_addr;
    logic        acc_write;
    logic        acc_err;
    logic [31:0] acc_rdata;
    logic        commit;
    logic        unused_prot;

    assign unused_prot = ^bus.prot[2:1];

    assign setup     = bus.psel && !bus.penable;
    assign setup_err = (32'(bus.addr) >= NUM_WORDS)
                     || (bus.pwrite && (bus.addr == 5'd0))
                     || (!bus.prot[0] && (32'(bus.addr) >= PRIV_BASE));

    // With zero wait states ACCESS is entered on the setup edge itself,
    // so the response must be formed from the live bus instead of the latches.
    assign acc_addr  = (state == IDLE) ? bus.addr   : lat_addr;
    assign acc_write = (state == IDLE) ? bus.pwrite : lat_write;
    assign acc_err   = (state == IDLE) ? setup_err  : lat_err;
    assign acc_rdata = (!acc_write && !acc_err)
                     ? ((acc_addr == 5'd0) ? ID_VALUE : mem[acc_addr])
                     : 32'h0;

    assign commit = (state == ACCESS) && lat_write && !lat_err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (setup) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_CYCLES[3:0];
                    end
                end
            end
            WAIT: begin
                if (!bus.psel) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd1) begin
                    state_nxt = ACCESS;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= 32'h0;
            lat_addr    <= 5'd0;
            lat_write   <= 1'b0;
            lat_err     <= 1'b0;
            lat_wdata   <= 32'h0;
            lat_strb    <= 4'h0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            if ((state == IDLE) && setup) begin
                lat_addr  <= bus.addr;
                lat_write <= bus.pwrite;
                lat_err   <= setup_err;
                lat_wdata <= bus.pwdata;
                lat_strb  <= bus.pstrobe;
            end
            // Only the entry edge into ACCESS produces a response; every other edge clears it.
            bus.pready  <= (state_nxt == ACCESS);
            bus.pslverr <= (state_nxt == ACCESS) && acc_err;
            bus.prdata  <= (state_nxt == ACCESS) ? acc_rdata : 32'h0;
            if (commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (lat_strb[b]) begin
                        mem[lat_addr][8*b +: 8] <= lat_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile with WAIT_CYCLES=1: latency, strobes, errors, abort, reset.
module tb_apb_completer_regfile;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   fails   = 0;

    apb_completer_regfile_if bus();

    apb_completer_regfile #(
        .WAIT_CYCLES(1),
        .NUM_WORDS  (32),
        .PRIV_BASE  (24),
        .ID_VALUE   (ID)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pready"},  {31'b0, bus.pready},  32'h0);
        chk({tag, "_pslverr"}, {31'b0, bus.pslverr}, 32'h0);
        chk({tag, "_prdata"},  bus.prdata,           32'h0);
    endtask

    // Called just after a rising edge; returns just after the ACCESS exit edge with psel low.
    task automatic xfer(input string tag, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                        input logic exp_err, input logic [31:0] exp_rd);
        int edges;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = w;
        bus.addr    = a;
        bus.pwdata  = d;
        bus.pstrobe = s;
        bus.prot    = p;
        @(posedge clk);
        #1;
        bus.penable = 1'b1;
        bus.addr    = ~a;
        bus.pwdata  = ~d;
        bus.pstrobe = ~s;
        edges = 1;
        @(negedge clk);
        while (!bus.pready && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, edges, 32'd2);
        chk({tag, "_pslverr"}, {31'b0, bus.pslverr}, {31'b0, exp_err});
        chk({tag, "_prdata"},  bus.prdata, exp_rd);
        @(posedge clk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.addr    = 5'd0;
        bus.prot    = 3'b000;
        bus.pstrobe = 4'h0;
        bus.pwdata  = 32'h0;

        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk_quiet("reset");
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_quiet("idle");
        end
        @(posedge clk);
        #1;

        xfer("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 3'b001, 1'b0, 32'h0);
        xfer("rd5", 1'b0, 5'd5, 32'h0,        4'h0, 3'b001, 1'b0, 32'hDEADBEEF);

        xfer("wr7_full",  1'b1, 5'd7, 32'h11223344, 4'hF,    3'b001, 1'b0, 32'h0);
        xfer("wr7_lanes", 1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 3'b001, 1'b0, 32'h0);
        xfer("rd7_lanes", 1'b0, 5'd7, 32'h0,        4'h0,    3'b001, 1'b0, 32'h11BB33DD);
        xfer("wr7_none",  1'b1, 5'd7, 32'hFFFFFFFF, 4'h0,    3'b001, 1'b0, 32'h0);
        xfer("rd7_none",  1'b0, 5'd7, 32'h0,        4'h0,    3'b001, 1'b0, 32'h11BB33DD);

        xfer("wr0_id", 1'b1, 5'd0, 32'h12121212, 4'hF, 3'b001, 1'b1, 32'h0);
        xfer("rd0_id", 1'b0, 5'd0, 32'h0,        4'h0, 3'b001, 1'b0, ID);

        xfer("wr24_priv",   1'b1, 5'd24, 32'hCAFEF00D, 4'hF, 3'b001, 1'b0, 32'h0);
        xfer("rd24_unpriv", 1'b0, 5'd24, 32'h0,        4'h0, 3'b000, 1'b1, 32'h0);
        xfer("wr24_unpriv", 1'b1, 5'd24, 32'h0BADBAD0, 4'hF, 3'b110, 1'b1, 32'h0);
        xfer("rd24_priv",   1'b0, 5'd24, 32'h0,        4'h0, 3'b001, 1'b0, 32'hCAFEF00D);

        // Back-to-back: the read's setup phase follows the write's ACCESS cycle directly.
        xfer("b2b_wr3", 1'b1, 5'd3, 32'h12345678, 4'hF, 3'b001, 1'b0, 32'h0);
        xfer("b2b_rd3", 1'b0, 5'd3, 32'h0,        4'h0, 3'b001, 1'b0, 32'h12345678);

        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.addr    = 5'd3;
        bus.pwdata  = 32'hFFFFFFFF;
        bus.pstrobe = 4'hF;
        bus.prot    = 3'b001;
        @(posedge clk);
        #1;
        bus.psel = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_pready", {31'b0, bus.pready}, 32'h0);
        end
        @(posedge clk);
        #1;
        xfer("abort_rd3", 1'b0, 5'd3, 32'h0, 4'h0, 3'b001, 1'b0, 32'h12345678);

        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.addr    = 5'd9;
        bus.pwdata  = 32'h55AA55AA;
        bus.pstrobe = 4'hF;
        bus.prot    = 3'b001;
        @(posedge clk);
        #1;
        bus.penable = 1'b1;
        reset       = 1'b1;
        @(negedge clk);
        chk("rst_mid_wait_pready", {31'b0, bus.pready}, 32'h0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_quiet("rst_mid_after");
        end
        @(posedge clk);
        #1;
        xfer("rst_rd9", 1'b0, 5'd9, 32'h0, 4'h0, 3'b001, 1'b0, 32'h0);
        xfer("rst_rd5", 1'b0, 5'd5, 32'h0, 4'h0, 3'b001, 1'b0, 32'h0);
        xfer("rst_rd0", 1'b0, 5'd0, 32'h0, 4'h0, 3'b000, 1'b0, ID);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/apb_completer_regfile.md
Name: apb_completer_regfile

Overview:
- APB completer (slave) end of the team's APB bus: answers the transfers that our APB master issues.
- Holds a 32 x 32-bit register file with byte-lane write strobes and a configurable number of wait states.
- Raises pslverr on illegal accesses: read-only ID register, privileged window, out-of-range address.
- Sits behind the master's psel/penable handshake as a drop-in peripheral model and synthesizable block.

Parameters:
- WAIT_CYCLES, 1, access-phase cycles with pready=0 before pready=1 (0..15).
- NUM_WORDS, 32, implemented words; addr >= NUM_WORDS is out of range.
- PRIV_BASE, 24, first word index that requires privileged access (prot[0]=1).
- ID_VALUE, 32'hA9B0_0001, constant returned by word 0 (read-only).

Ports:
- clk  input  1  single clock; everything updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- psel  input  1  completer select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1=write, 0=read.
- addr  input  5  word index.
- prot  input  3  protection; bit0=privileged, bits 2:1 ignored.
- pstrobe  input  4  write byte lanes; ignored on reads.
- pwdata  input  32  write data.
- pready  output  1  transfer complete (registered).
- pslverr  output  1  error response, valid only while pready=1 (registered).
- prdata  output  32  read data, valid only while pready=1 and pwrite=0 (registered).

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; pready=0, pslverr=0, prdata=0.
  - Words 1..NUM_WORDS-1 cleared to 0.
  - Reset wins over any in-flight transfer; an in-flight write is discarded.
- States are IDLE, WAIT and ACCESS.
- IDLE:
  - pready=0, pslverr=0, prdata=0.
  - On an edge with psel=1 and penable=0 (setup phase): latch addr, pwrite, pwdata, pstrobe and prot.
  - Evaluate err, where err = (addr>=NUM_WORDS) | (pwrite & addr==0) | (!prot[0] & addr>=PRIV_BASE).
  - If WAIT_CYCLES=0, go to ACCESS, else go to WAIT with cnt=WAIT_CYCLES.
  - psel=1 with penable=1 while in IDLE is a protocol error: ignored, stay in IDLE.
- WAIT:
  - pready=0.
  - psel=0 means the master aborted: go to IDLE, no side effects.
  - Otherwise cnt decrements; on the edge where cnt==1, go to ACCESS.
- Entering ACCESS (registered on that edge):
  - pready<=1 and pslverr<=err.
  - prdata <= (read & !err) ? (addr==0 ? ID_VALUE : mem[addr]) : 0.
- ACCESS:
  - pready=1 for exactly one cycle.
  - On the edge leaving ACCESS, if write and !err: mem[addr] byte lane i <= pwdata[8i+7:8i] for each pstrobe[i]=1.
  - pstrobe=0 completes with no change.
  - Errored writes never modify memory.
  - Then go to IDLE with pready, pslverr and prdata back to 0.
- Latency:
  - Setup edge to pready=1 is WAIT_CYCLES+1 edges.
  - A transfer occupies WAIT_CYCLES+2 cycles including setup.
  - Back-to-back transfers (new setup phase in the cycle after pready=1) are accepted with no idle cycle.
- Read-after-write to the same address returns the new data: the write commits on the ACCESS exit edge, before the next read's ACCESS entry.
- Inputs that change during WAIT or ACCESS are ignored; the latched values are used.

Test Plan:
- Reset then idle: hold reset=1 for 2 cycles, then psel=0 for 5 cycles -> pready=0, pslverr=0, prdata=0 throughout.
- Write/read, WAIT_CYCLES=1:
  - Stimulus: write addr=5, pwdata=32'hDEADBEEF, pstrobe=4'hF, prot=3'b001; then read addr=5.
  - Required: pready=1 exactly 2 edges after each setup edge, pslverr=0, prdata=32'hDEADBEEF.
- Byte strobes:
  - Stimulus: write addr=7 32'h11223344 strobe 4'hF; then write 32'hAABBCCDD strobe 4'b0101; read addr=7.
  - Required: 32'h11BB33DD.
- Errors:
  - Write addr=0 -> pslverr=1, and a subsequent read of addr=0 returns ID_VALUE.
  - Read addr=24 with prot=3'b000 -> pslverr=1, prdata=0.
  - Same read with prot=3'b001 -> pslverr=0.
- Back-to-back and abort:
  - Back-to-back: write addr=3 immediately followed by a setup phase for read addr=3 -> both complete, read returns the written data, no idle cycle between transfers.
  - Abort: drop psel during WAIT -> return to IDLE and memory unchanged.
- Reset mid-transfer: assert reset in the WAIT cycle of a write to addr=9 -> pready stays 0 and a later read of addr=9 returns 0.
